// File: rtl/router_pkg.sv
// Shared router constants and the receive-side deserializer state encoding.
package router_pkg;
    localparam int NUM_PORTS  = 8;
    localparam int PORT_W     = 3;
    localparam int PKT_DATA_W = 32;

    typedef enum logic [1:0] {ARM, IDLE, RECV, DROP} deser_state_t;
endpackage

// File: rtl/port_deserializer_if.sv
// Host-side valid/ready word bus of one port deserializer.
interface port_deserializer_if #(parameter int DATA_W = 32);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/port_deser_fifo.sv
// Show-ahead word FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module port_deser_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     accept,
    output logic                     valid,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;

    assign valid  = (count != '0);
    assign accept = push && ((count != (AW+1)'(DEPTH)) || pop);
    // Head reads as zero when empty so the bus shows 0 out of reset.
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/port_deserializer.sv
// Reassembles one router output port's LSB-first serial packets into words and buffers them.
// Optional length checking is built when PORT_DESER_ERRCHK_EN is defined.
module port_deserializer
    import router_pkg::*;
#(
    parameter int DATA_W     = PKT_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PORT_ID    = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_n,
    input  logic                          valid_n,
    input  logic                          din,
    port_deserializer_if.master           out_bus,
    output logic [PORT_W-1:0]             out_port,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          err_len,
    output logic [7:0]                    pkt_count
);
    localparam int BW = $clog2(DATA_W + 1);

    deser_state_t      state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt, bit_word;
    logic [BW-1:0]     bit_cnt, cnt_nxt;
    logic              eop, len_ok, push, pop, accept;

    assign out_port = PORT_W'(PORT_ID);
    assign pop      = out_bus.out_valid && out_bus.out_ready;
    // A bit beyond DATA_W shifts out of range and leaves the word untouched.
    assign bit_word = shift | ({{(DATA_W-1){1'b0}}, din} << bit_cnt);

`ifdef PORT_DESER_ERRCHK_EN
    logic drop_end;
`endif

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        eop       = 1'b0;
        len_ok    = 1'b0;
`ifdef PORT_DESER_ERRCHK_EN
        drop_end  = 1'b0;
`endif
        case (state)
            ARM: if (frame_n) state_nxt = IDLE;
            IDLE: begin
                shift_nxt = '0;
                cnt_nxt   = '0;
                if (!valid_n) begin
                    if (frame_n) begin
                        eop    = 1'b1;
                        len_ok = (DATA_W == 1);
                    end else begin
                        shift_nxt = bit_word;
                        cnt_nxt   = BW'(1);
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (!valid_n) begin
                    if (bit_cnt == BW'(DATA_W)) begin
                        if (frame_n) begin
                            eop       = 1'b1;
                            state_nxt = IDLE;
                            shift_nxt = '0;
                            cnt_nxt   = '0;
                        end
`ifdef PORT_DESER_ERRCHK_EN
                        else state_nxt = DROP;
`endif
                    end else if (frame_n) begin
                        eop       = 1'b1;
                        len_ok    = (bit_cnt == BW'(DATA_W - 1));
                        state_nxt = IDLE;
                        shift_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        shift_nxt = bit_word;
                        cnt_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef PORT_DESER_ERRCHK_EN
            DROP: begin
                if (frame_n) begin
                    drop_end  = 1'b1;
                    state_nxt = IDLE;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PORT_DESER_ERRCHK_EN
    assign push = eop && len_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_len <= 1'b0;
        else          err_len <= (eop && !len_ok) || drop_end;
    end
`else
    logic unused_len_ok;
    assign unused_len_ok = len_ok;
    assign push          = eop;
    assign err_len       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARM;
            shift     <= '0;
            bit_cnt   <= '0;
            overflow  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            overflow  <= push && !accept;
            if (accept) pkt_count <= pkt_count + 1'b1;
        end
    end

    port_deser_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bit_word),
        .pop       (pop),
        .accept    (accept),
        .valid     (out_bus.out_valid),
        .head      (out_bus.out_data),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_port_deserializer.sv
// Directed bench for port_deserializer: framing, stalls, overflow, full push+pop, length and reset handling.
module tb_port_deserializer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_n = 1'b1;
    logic       valid_n = 1'b1;
    logic       din = 1'b0;
    logic [2:0] out_port;
    logic [2:0] fifo_count;
    logic       overflow, err_len;
    logic [7:0] pkt_count;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int ovf_seen = 0, err_seen = 0;
    int exp_pkt = 0, exp_err = 0;

    port_deserializer_if #(.DATA_W(32)) bus ();

    port_deserializer #(.DATA_W(32), .FIFO_DEPTH(4), .PORT_ID(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .din        (din),
        .out_bus    (bus.master),
        .out_port   (out_port),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .err_len    (err_len),
        .pkt_count  (pkt_count)
    );

    always #5 clock = ~clock;

    // Pulses are counted from the value held just before the next active edge.
    always @(posedge clock) begin
        if (reset_n && overflow) ovf_seen++;
        if (reset_n && err_len)  err_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input int nbits, input bit term,
                        input int stall_at, input int stall_len);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            valid_n = 1'b0;
            din     = d[i];
            frame_n = term && (i == nbits - 1);
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clock);
                    valid_n = 1'b1;
                    frame_n = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            valid_n       = 1'b1;
            frame_n       = 1'b1;
            din           = 1'b0;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.out_data), 64'(exp));
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  64'(bus.out_data), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_err",   64'(err_len), 64'd0);
        chk("rst_pkt",   64'(pkt_count), 64'd0);
        chk("port_id",   64'(out_port), 64'd5);
        reset_n = 1'b1;
        idle(2);

        // Word is visible on the negedge right after its last bit's edge.
        send(64'hDEADBEEF, 32, 1'b1, -1, 0);
        idle(1);
        chk("smoke_valid", 64'(bus.out_valid), 64'd1);
        chk("smoke_data",  64'(bus.out_data), 64'hDEADBEEF);
        chk("smoke_pkt",   64'(pkt_count), 64'd1);
        pop_chk("smoke_pop", 32'hDEADBEEF);
        chk("smoke_empty", 64'(bus.out_valid), 64'd0);

        send(64'h12341234, 32, 1'b1, 10, 3);
        idle(2);
        chk("stall_err", 64'(err_seen), 64'd0);
        chk("stall_pkt", 64'(pkt_count), 64'd2);
        pop_chk("stall", 32'h12341234);

        // Back-to-back packets into a stalled consumer; the fifth is dropped.
        for (int v = 1; v <= 5; v++) send(64'(v), 32, 1'b1, -1, 0);
        idle(2);
        chk("ovf_count", 64'(fifo_count), 64'd4);
        chk("ovf_pulse", 64'(ovf_seen), 64'd1);
        chk("ovf_pkt",   64'(pkt_count), 64'd6);
        idle(1);
        chk("ovf_hold",  64'(bus.out_data), 64'd1);

        // Pop lands on the same edge as the last bit of a push into a full FIFO.
        send(64'd6, 32, 1'b1, -1, 0);
        bus.out_ready = 1'b1;
        idle(2);
        chk("fullpp_count", 64'(fifo_count), 64'd4);
        chk("fullpp_ovf",   64'(ovf_seen), 64'd1);
        chk("fullpp_pkt",   64'(pkt_count), 64'd7);
        pop_chk("drain2", 32'd2);
        pop_chk("drain3", 32'd3);
        pop_chk("drain4", 32'd4);
        pop_chk("drain6", 32'd6);
        chk("drain_count", 64'(fifo_count), 64'd0);
        exp_pkt = 7;

        send(64'hABCDE, 20, 1'b1, -1, 0);
        idle(2);
`ifdef PORT_DESER_ERRCHK_EN
        exp_err++;
        chk("short_count", 64'(fifo_count), 64'd0);
`else
        exp_pkt++;
        pop_chk("short", 32'h000ABCDE);
`endif
        chk("short_err", 64'(err_seen), 64'(exp_err));
        chk("short_pkt", 64'(pkt_count), 64'(exp_pkt));

        send(64'hF_CAFEF00D, 36, 1'b1, -1, 0);
        idle(2);
`ifdef PORT_DESER_ERRCHK_EN
        exp_err++;
        chk("long_count", 64'(fifo_count), 64'd0);
`else
        exp_pkt++;
        pop_chk("long", 32'hCAFEF00D);
`endif
        chk("long_err", 64'(err_seen), 64'(exp_err));
        chk("long_pkt", 64'(pkt_count), 64'(exp_pkt));

        // One-bit packet; when pushed it is left queued for the reset to clear.
        send(64'd1, 1, 1'b1, -1, 0);
        idle(2);
`ifdef PORT_DESER_ERRCHK_EN
        exp_err++;
        chk("one_count", 64'(fifo_count), 64'd0);
`else
        exp_pkt++;
        chk("one_data",  64'(bus.out_data), 64'd1);
        chk("one_count", 64'(fifo_count), 64'd1);
`endif
        chk("one_err", 64'(err_seen), 64'(exp_err));
        chk("one_pkt", 64'(pkt_count), 64'(exp_pkt));

        // Reset lands after bit 14; frame stays low across release.
        send(64'h5A5A_C3C3, 15, 1'b0, -1, 0);
        @(negedge clock);
        reset_n = 1'b0;
        valid_n = 1'b1;
        frame_n = 1'b0;
        @(negedge clock);
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_count", 64'(fifo_count), 64'd0);
        chk("mrst_pkt",   64'(pkt_count), 64'd0);
        reset_n = 1'b1;
        send(64'h5A5A_C3C3 >> 15, 17, 1'b1, -1, 0);
        idle(2);
        chk("arm_count", 64'(fifo_count), 64'd0);
        chk("arm_pkt",   64'(pkt_count), 64'd0);
        send(64'h0000_1111, 32, 1'b1, -1, 0);
        idle(2);
        chk("post_pkt",   64'(pkt_count), 64'd1);
        chk("post_count", 64'(fifo_count), 64'd1);
        pop_chk("post", 32'h0000_1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/port_deserializer.md
# port_deserializer

Receive-side stage that sits directly downstream of one router output port. It consumes the serial stream from that port (frameo_n, valido_n, dout), reassembles each 32-bit payload LSB-first, and buffers completed words in a small FIFO. Words are presented to the host logic on a valid/ready interface. One instance is placed per router output port, eight in total.

## Interface
- DATA_W, 32: payload bits per packet.
- FIFO_DEPTH, 4: word buffer depth; must be a power of two and at least 2.
- PORT_ID, 0: router output port number (0..7) reported on out_port.

- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- frame_n  in  1  from router frameo_n[PORT_ID]; active-low frame.
- valid_n  in  1  from router valido_n[PORT_ID]; active-low bit valid.
- din  in  1  from router dout[PORT_ID]; serial data.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_W  head-of-FIFO payload (show-ahead).
- out_port  out  3  constant PORT_ID.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- err_len  out  1  one-cycle pulse on a length error (see Configuration).
- pkt_count  out  8  count of words pushed; wraps 255 -> 0.

## Operation
- A bit is sampled on a rising edge when valid_n == 0. Bit k of a packet goes to shift[k]. Bits are LSB first.
- The last bit of a packet is the one sampled with valid_n == 0 and frame_n == 1, i.e. frame_n deasserts together with the last valid bit.
- The FSM has four states:
  - ARM (reset state): wait for frame_n == 1, then go to IDLE. This prevents capturing a packet that was already in progress when reset released.
  - IDLE: the shift register is held at 0. On valid_n == 0 with frame_n == 0, store bit 0, set bit_cnt = 1, and go to RECV. On valid_n == 0 with frame_n == 1 (a 1-bit packet), end the packet immediately with bit_cnt = 1.
  - RECV: each valid bit is stored at bit_cnt and bit_cnt increments.
    - valid_n == 1 mid-frame is a stall: hold state and count.
    - On the last bit, end the packet and return to IDLE.
    - A valid bit sampled with bit_cnt == DATA_W and frame_n == 0 is an over-length packet: go to DROP.
  - DROP: discard input until frame_n == 1 is sampled (any valid_n), then go to IDLE. No push occurs.
- End of packet: the packet is length-correct if the total number of bits equals DATA_W. Handling of length-correct and incorrect packets is defined under Configuration.
- Push rule: a push is accepted if fifo_count < FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the word is lost and overflow pulses.
- Pop occurs when out_valid && out_ready.
- pkt_count increments once per accepted push.

## Timing
- Reset values: out_valid 0, out_data 0, fifo_count 0, overflow 0, err_len 0, pkt_count 0, FSM state ARM.
- Reset mid-packet clears all state and FIFO contents immediately. The partial packet is never delivered.
- Latency: the word whose last bit is sampled at edge N is written at edge N. out_valid rises after edge N when the FIFO was empty, so the word is visible one cycle after its last bit.
- Back-to-back packets need no idle gap. A start bit may be sampled at edge N+1.
- overflow and err_len are registered single-cycle pulses asserted after edge N.
- out_data must remain stable while out_valid && !out_ready.
- Simultaneous push and pop on an empty FIFO: the pop is impossible because out_valid is 0, so only the push happens.

## Configuration
- PORT_DESER_ERRCHK_EN defined:
  - A packet ending with a bit total other than DATA_W (short, or over-length via DROP) pulses err_len and is discarded.
- PORT_DESER_ERRCHK_EN not defined:
  - There is no DROP state. Bits beyond DATA_W are ignored, and the word is pushed at frame end.
  - Short packets are pushed with the missing upper bits as 0.
  - err_len is tied to 0.

## Structure
- The shared package router_pkg holds:
  - NUM_PORTS = 8, PORT_W = 3, PKT_DATA_W = 32, which is the default for DATA_W;
  - the enum deser_state_t {ARM, IDLE, RECV, DROP}.
- One sub-module, port_deser_fifo: a synchronous show-ahead FIFO with simultaneous read/write when full.
- Shift register, bit counter and FSM stay in port_deserializer.

## Test plan
- Smoke: after reset, send 32'hDEADBEEF LSB-first with frame_n deasserting on bit 31 -> out_valid one cycle after the last bit, out_data = DEADBEEF, pkt_count = 1.
- Stalls: 32'h12341234 with valid_n = 1 for 3 cycles after bit 10 -> out_data = 12341234, no err_len.
- Overflow: 5 packets 0x1..0x5 with out_ready = 0, depth 4 -> fifo_count = 4, one overflow pulse, then pops return 1, 2, 3, 4.
- Full push + pop: FIFO full, out_ready = 1 on the cycle of the last bit -> push accepted, fifo_count stays 4, no overflow.
- Length error (macro on): 20-bit packet -> err_len pulse, nothing pushed. Macro off: the same packet is pushed with bits [31:20] = 0.
- Reset mid-packet at bit 15 with frame_n held low through reset release -> ARM ignores the remainder. The next clean packet 32'h0000_1111 is received correctly.
